mux4_rr_arbiter: RTL



---
 rtl/mux4_rr_arbiter_pkg.sv | 22 ++
 rtl/mux4_rr_arbiter_mux4_1_2b.sv | 18 +
 rtl/mux4_rr_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the 4-requester round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DEFAULT_MAX_HOLD = 8;

  // Result of a round-robin search: whether any request was found, and which.
  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // One-hot (or zero) 4-bit vector to its 2-bit index; zero maps to 0.
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4_1_2b.sv
// Structural 2-bit 4:1 mux: a two-level tree of 2:1 selects on s.
module mux4_1_2b (
  input  logic [1:0] i0,
  input  logic [1:0] i1,
  input  logic [1:0] i2,
  input  logic [1:0] i3,
  input  logic [1:0] s,
  output logic [1:0] o
);

  logic [1:0] lo;
  logic [1:0] hi;

  assign lo = s[0] ? i1 : i0;
  assign hi = s[0] ? i3 : i2;
  assign o  = s[1] ? hi : lo;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 2-bit 4:1 mux among four requesters,
// with a per-tenure hold limit and a gated mux output.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             sel_valid,
  output logic [WIDTH-1:0] o,
  output logic             timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux4_rr_arbiter: MAX_HOLD must be in 2..255");
  end
  if ((64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_cnt_w
    $error("mux4_rr_arbiter: CNT_W too narrow for MAX_HOLD");
  end
  if (WIDTH != 2) begin : g_bad_width
    $error("mux4_rr_arbiter: the shared mux is fixed at 2 bits");
  end

  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [1:0]       owner;
  logic             own_req;
  pick_t            pick_any;
  pick_t            pick_other;
  logic [1:0]       mux_o;

  // First asserted bit of r in the order p, p+1, p+2, p+3 (mod 4).
  // Scanning from the farthest offset down lets the nearest one win last.
  function automatic pick_t rr_pick(input logic [3:0] r, input logic [1:0] p);
    pick_t      res;
    logic [1:0] k;
    res = '0;
    for (int i = 3; i >= 0; i--) begin
      k = p + 2'(i);
      if (r[k]) begin
        res.found = 1'b1;
        res.idx   = k;
      end
    end
    return res;
  endfunction

  // Owner decode and the two round-robin searches (fresh and handoff).
  always_comb begin
    owner      = onehot_to_idx(gnt);
    own_req    = req[owner];
    pick_any   = rr_pick(req, ptr);
    pick_other = rr_pick(req & ~gnt, ptr);
  end

  // Arbitration FSM: grant, hold, time out and hand off, all registered.
  // NOTE: every register here uses <= so all updates see pre-edge values; the
  // synchronous reset branch comes first so it overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
      timeout   <= 1'b0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any.found) begin
            state     <= GRANT;
            gnt       <= 4'(1) << pick_any.idx;
            sel       <= pick_any.idx;
            sel_valid <= 1'b1;
            ptr       <= pick_any.idx + 2'd1;
            hold_cnt  <= '0;
          end
        end
        GRANT: begin
          if (own_req && hold_cnt != LAST_CYCLE) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else begin
            // Release or hold limit reached: hand off on this same edge.
            timeout  <= own_req;
            hold_cnt <= '0;
            if (pick_other.found) begin
              gnt <= 4'(1) << pick_other.idx;
              sel <= pick_other.idx;
              ptr <= pick_other.idx + 2'd1;
            end else if (!own_req) begin
              state     <= IDLE;
              gnt       <= '0;
              sel       <= '0;
              sel_valid <= 1'b0;
            end
            // Otherwise the owner is re-granted as a new tenure; ptr stays.
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mux4_1_2b u_mux (
    .i0 (i0),
    .i1 (i1),
    .i2 (i2),
    .i3 (i3),
    .s  (sel),
    .o  (mux_o)
  );

  assign o = mux_o & {WIDTH{sel_valid}};

endmodule
